// File: rtl/mem_access_ctrl_pkg.sv
// ============================================================================
// Module : mem_access_ctrl_pkg
// Brief  : Shared constants for the MEM-stage data-memory access controller:
//          datapath width default, load/store op encodings, access sizes,
//          FSM state type and the misalignment predicate.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_access_ctrl_pkg;

    localparam int PROC_BITS_DEF = 32;

    // Load/store op codes; bits[1:0] carry the access size, bit 2 the unsigned flag
    localparam logic [2:0] LS_LB  = 3'b000;
    localparam logic [2:0] LS_LH  = 3'b001;
    localparam logic [2:0] LS_LW  = 3'b011;
    localparam logic [2:0] LS_LBU = 3'b100;
    localparam logic [2:0] LS_LHU = 3'b101;

    localparam logic [1:0] SZ_BYTE = LS_LB[1:0];
    localparam logic [1:0] SZ_HALF = LS_LH[1:0];
    localparam logic [1:0] SZ_WORD = LS_LW[1:0];

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Half needs a[0]=0, word needs a[1:0]=00; any non-byte/non-half code is a word
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (size == SZ_HALF) begin
            mis = addr_lo[0];
        end else if (size != SZ_BYTE) begin
            mis = (addr_lo != 2'b00);
        end
        return mis;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
// Module : mem_lane_align
// Brief  : Combinational byte-lane steering. Store side produces byte enables
//          and lane-replicated write data; load side right-aligns the read
//          word and zero-fills the upper bits. Size codes: 00 byte, 01 half,
//          anything else word. Half uses a[1] only, word ignores a[1:0].
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_lane_align
    import mem_access_ctrl_pkg::*;
#(
    parameter int PROC_BITS = PROC_BITS_DEF
) (
    input  logic [1:0]           st_size_i,
    input  logic [1:0]           st_addr_lo_i,
    input  logic [PROC_BITS-1:0] st_data_i,
    output logic [3:0]           st_be_o,
    output logic [PROC_BITS-1:0] st_wdata_o,
    input  logic [1:0]           ld_size_i,
    input  logic [1:0]           ld_addr_lo_i,
    input  logic [PROC_BITS-1:0] ld_rdata_i,
    output logic [PROC_BITS-1:0] ld_data_o
);

    logic [PROC_BITS-1:0] byte_sh;
    logic [PROC_BITS-1:0] half_sh;

    // Store: pick byte enables from the low address bits and replicate the source across lanes
    always_comb begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_data_i;
        case (st_size_i)
            SZ_BYTE: begin
                st_be_o    = 4'b0001 << st_addr_lo_i;
                st_wdata_o = {(PROC_BITS/8){st_data_i[7:0]}};
            end
            SZ_HALF: begin
                st_be_o    = st_addr_lo_i[1] ? 4'b1100 : 4'b0011;
                st_wdata_o = {(PROC_BITS/16){st_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Load: shift the addressed lane down to bit 0 and clear everything above the access size
    always_comb begin
        byte_sh   = ld_rdata_i >> {ld_addr_lo_i, 3'b000};
        half_sh   = ld_rdata_i >> {ld_addr_lo_i[1], 4'b0000};
        ld_data_o = ld_rdata_i;
        case (ld_size_i)
            SZ_BYTE: ld_data_o = byte_sh & {{(PROC_BITS-8){1'b0}}, 8'hFF};
            SZ_HALF: ld_data_o = half_sh & {{(PROC_BITS-16){1'b0}}, 16'hFFFF};
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module : mem_access_ctrl
// Brief  : MEM-stage data-memory access controller. Two-state FSM (IDLE/WAIT)
//          latches a load/store, holds a registered memory request until the
//          one-cycle ack, stalls upstream meanwhile and returns right-aligned
//          load data with a one-cycle valid pulse.
//          Optional feature: define MISALIGN_TRAP_EN to trap misaligned
//          half/word accesses (no request, one-cycle o_misalign pulse).
//          Undefined, offending low address bits are ignored.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int PROC_BITS = PROC_BITS_DEF
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_valid,
    input  logic                 i_mem_read,
    input  logic                 i_mem_write,
    input  logic [2:0]           i_ls_op,
    input  logic [PROC_BITS-1:0] i_addr,
    input  logic [PROC_BITS-1:0] i_store_data,
    output logic                 o_stall,
    output logic                 o_dmem_req,
    output logic                 o_dmem_we,
    output logic [PROC_BITS-1:0] o_dmem_addr,
    output logic [PROC_BITS-1:0] o_dmem_wdata,
    output logic [3:0]           o_dmem_be,
    input  logic                 i_dmem_ack,
    input  logic [PROC_BITS-1:0] i_dmem_rdata,
    output logic [PROC_BITS-1:0] o_load_data,
    output logic [2:0]           o_load_op,
    output logic                 o_load_valid,
    output logic                 o_misalign
);

    state_e               state_q;
    logic                 is_store_q;
    logic [2:0]           op_q;
    logic [1:0]           addr_lo_q;
    logic                 dmem_req_q;
    logic                 dmem_we_q;
    logic [PROC_BITS-1:0] dmem_addr_q;
    logic [PROC_BITS-1:0] dmem_wdata_q;
    logic [3:0]           dmem_be_q;
    logic [PROC_BITS-1:0] load_data_q;
    logic [2:0]           load_op_q;
    logic                 load_valid_q;
    logic                 misalign_q;

    logic                 access;
    logic                 is_store;
    logic                 misaligned;
    logic                 accept;
    logic [3:0]           st_be;
    logic [PROC_BITS-1:0] st_wdata;
    logic [PROC_BITS-1:0] ld_data;

    // A simultaneous read+write is a store; the read is dropped
    assign access   = i_valid & (i_mem_read | i_mem_write);
    assign is_store = i_mem_write;

`ifdef MISALIGN_TRAP_EN
    assign misaligned = is_misaligned(i_ls_op[1:0], i_addr[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign accept  = (state_q == ST_IDLE) & access & ~misaligned;
    // Upstream is released in the ack cycle so the next access lands in the following IDLE cycle
    assign o_stall = accept | ((state_q == ST_WAIT) & ~i_dmem_ack);

    mem_lane_align #(
        .PROC_BITS (PROC_BITS)
    ) u_lane_align (
        .st_size_i    (i_ls_op[1:0]),
        .st_addr_lo_i (i_addr[1:0]),
        .st_data_i    (i_store_data),
        .st_be_o      (st_be),
        .st_wdata_o   (st_wdata),
        .ld_size_i    (op_q[1:0]),
        .ld_addr_lo_i (addr_lo_q),
        .ld_rdata_i   (i_dmem_rdata),
        .ld_data_o    (ld_data)
    );

    // Access FSM with registered memory-side and load-return outputs
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= ST_IDLE;
            is_store_q   <= 1'b0;
            op_q         <= 3'b000;
            addr_lo_q    <= 2'b00;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_be_q    <= 4'b0000;
            load_data_q  <= '0;
            load_op_q    <= 3'b000;
            load_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            load_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q      <= ST_WAIT;
                        is_store_q   <= is_store;
                        op_q         <= i_ls_op;
                        addr_lo_q    <= i_addr[1:0];
                        dmem_req_q   <= 1'b1;
                        dmem_we_q    <= is_store;
                        dmem_addr_q  <= {i_addr[PROC_BITS-1:2], 2'b00};
                        dmem_be_q    <= is_store ? st_be : 4'b1111;
                        dmem_wdata_q <= is_store ? st_wdata : '0;
                    end else if (access & misaligned) begin
                        misalign_q   <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (i_dmem_ack) begin
                        state_q    <= ST_IDLE;
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        if (!is_store_q) begin
                            load_data_q  <= ld_data;
                            load_op_q    <= op_q;
                            load_valid_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign o_dmem_req   = dmem_req_q;
    assign o_dmem_we    = dmem_we_q;
    assign o_dmem_addr  = dmem_addr_q;
    assign o_dmem_wdata = dmem_wdata_q;
    assign o_dmem_be    = dmem_be_q;
    assign o_load_data  = load_data_q;
    assign o_load_op    = load_op_q;
    assign o_load_valid = load_valid_q;
    assign o_misalign   = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module : tb_mem_access_ctrl
// Brief  : Scoreboard bench for mem_access_ctrl. A byte-addressed reference
//          memory predicts requests and load results; monitors compare what
//          the DUT presents. A word memory answers requests with variable
//          latency and occasional stray acks while idle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_valid, i_mem_read, i_mem_write;
    logic [2:0]  i_ls_op;
    logic [31:0] i_addr, i_store_data;
    logic        o_stall, o_dmem_req, o_dmem_we;
    logic [31:0] o_dmem_addr, o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    logic [31:0] o_load_data;
    logic [2:0]  o_load_op;
    logic        o_load_valid, o_misalign;

    always #5 i_clock = ~i_clock;

    mem_access_ctrl #(.PROC_BITS(32)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_ls_op(i_ls_op),
        .i_addr(i_addr), .i_store_data(i_store_data), .o_stall(o_stall),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be), .i_dmem_ack(i_dmem_ack),
        .i_dmem_rdata(i_dmem_rdata), .o_load_data(o_load_data), .o_load_op(o_load_op),
        .o_load_valid(o_load_valid), .o_misalign(o_misalign)
    );

    typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; int cyc; } req_t;
    typedef struct { logic [31:0] data; logic [2:0] op; } ld_t;

    req_t rq[$];
    ld_t  lq[$];
    int   mq[$];

    logic [7:0]  ref_mem [0:1023];
    logic [31:0] mem     [0:255];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fixed_lat = -1;
    int last_lat = 0;
    int ld_ack_cyc = 0;
    bit inject_ack = 1'b0;

    always @(posedge i_clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic int nbytes(input logic [2:0] op);
        if (op[1:0] == 2'b00) return 1;
        if (op[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    task automatic set_word(input int a, input logic [31:0] v);
        mem[a/4] = v;
        for (int i = 0; i < 4; i++) ref_mem[(a & ~3) + i] = v[8*i +: 8];
    endtask

    // Memory responder: acks after a chosen latency, sometimes acks while idle
    initial begin
        bit busy;
        int cnt;
        busy = 1'b0;
        cnt = 0;
        i_dmem_ack = 1'b0;
        i_dmem_rdata = '0;
        forever begin
            @(negedge i_clock);
            #1;
            i_dmem_ack = 1'b0;
            i_dmem_rdata = $urandom;
            if (!i_reset) begin
                busy = 1'b0;
            end else if (o_dmem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                    last_lat = cnt;
                end
                if (cnt == 0) begin
                    busy = 1'b0;
                    i_dmem_ack = 1'b1;
                    if (o_dmem_we) begin
                        for (int k = 0; k < 4; k++)
                            if (o_dmem_be[k]) mem[o_dmem_addr[9:2]][8*k +: 8] = o_dmem_wdata[8*k +: 8];
                    end else begin
                        i_dmem_rdata = mem[o_dmem_addr[9:2]];
                        ld_ack_cyc = cyc;
                    end
                end else begin
                    cnt--;
                end
            end else if (inject_ack || $urandom_range(0, 7) == 0) begin
                inject_ack = 1'b0;
                i_dmem_ack = 1'b1;
            end
        end
    end

    // Request monitor: checks each new request and that it stays constant while pending
    initial begin
        bit prev;
        req_t e, cur;
        prev = 1'b0;
        cur = '{1'b0, 32'h0, 4'h0, 32'h0, 0};
        forever begin
            @(negedge i_clock);
            if (i_reset && o_dmem_req) begin
                if (!prev) begin
                    if (rq.size() == 0) begin
                        flag_fail("unexpected_dmem_req");
                    end else begin
                        e = rq.pop_front();
                        check("req_we", o_dmem_we, e.we);
                        check("req_addr", o_dmem_addr, e.addr);
                        check("req_be", o_dmem_be, e.be);
                        if (e.we) check("req_wdata", o_dmem_wdata, e.wdata);
                        check("req_issue_latency", cyc, e.cyc + 1);
                    end
                    cur = '{o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata, cyc};
                end else begin
                    check("hold_we", o_dmem_we, cur.we);
                    check("hold_addr", o_dmem_addr, cur.addr);
                    check("hold_be", o_dmem_be, cur.be);
                    check("hold_wdata", o_dmem_wdata, cur.wdata);
                end
            end
            prev = i_reset && o_dmem_req;
        end
    end

    // Load-result monitor
    initial begin
        ld_t e;
        forever begin
            @(negedge i_clock);
            if (o_load_valid) begin
                if (lq.size() == 0) begin
                    flag_fail("unexpected_load_valid");
                end else begin
                    e = lq.pop_front();
                    check("load_data", o_load_data, e.data);
                    check("load_op", o_load_op, e.op);
                    check("load_valid_timing", cyc, ld_ack_cyc + 1);
                end
            end
        end
    end

    // Misalignment pulse monitor
    initial begin
        int c;
        forever begin
            @(negedge i_clock);
            if (o_misalign) begin
                if (mq.size() == 0) begin
                    flag_fail("unexpected_misalign");
                end else begin
                    c = mq.pop_front();
                    check("misalign_timing", cyc, c + 1);
                end
            end
        end
    end

    // Issue one access, predict its effect, hold it until upstream is released
    task automatic issue(input bit rd, input bit wr, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] data);
        int n, ea, stalls;
        bit mis;
        req_t r;
        ld_t l;
        @(negedge i_clock);
        i_valid = 1'b1; i_mem_read = rd; i_mem_write = wr;
        i_ls_op = op; i_addr = addr; i_store_data = data;
        n   = nbytes(op);
        mis = TRAP && ((n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00));
        ea  = int'(addr[9:0]) & ~(n - 1);
        if (mis) begin
            mq.push_back(cyc);
        end else begin
            r.we = wr; r.addr = 32'(ea & ~3); r.cyc = cyc;
            r.be = wr ? 4'b0000 : 4'b1111;
            r.wdata = '0;
            for (int k = 0; k < 4; k++) r.wdata[8*k +: 8] = data[8*(k % n) +: 8];
            if (wr) begin
                for (int i = 0; i < n; i++) begin
                    r.be[(ea + i) % 4] = 1'b1;
                    ref_mem[ea + i] = data[8*i +: 8];
                end
            end else begin
                l.op = op; l.data = '0;
                for (int i = 0; i < n; i++) l.data[8*i +: 8] = ref_mem[ea + i];
                lq.push_back(l);
            end
            rq.push_back(r);
        end
        #2;
        stalls = 0;
        while (o_stall) begin
            stalls++;
            if (stalls > 64) begin
                flag_fail("stall_timeout");
                break;
            end
            @(negedge i_clock);
            #2;
        end
        if (mis) check("misalign_no_stall", stalls, 0);
        else     check("stall_cycles", stalls, 1 + last_lat);
    endtask

    task automatic idle_cycle();
        @(negedge i_clock);
        i_valid = 1'b0; i_mem_read = 1'($urandom); i_mem_write = 1'($urandom);
        i_addr = $urandom_range(0, 1023);
        #2;
        check("idle_no_stall", o_stall, 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req"}, o_dmem_req, 0);
        check({tag, "_we"}, o_dmem_we, 0);
        check({tag, "_addr"}, o_dmem_addr, 0);
        check({tag, "_wdata"}, o_dmem_wdata, 0);
        check({tag, "_be"}, o_dmem_be, 0);
        check({tag, "_load_data"}, o_load_data, 0);
        check({tag, "_load_op"}, o_load_op, 0);
        check({tag, "_load_valid"}, o_load_valid, 0);
        check({tag, "_misalign"}, o_misalign, 0);
        check({tag, "_stall"}, o_stall, 0);
    endtask

    initial begin
        logic [2:0] ops [5];
        int sel;
        ops[0] = LS_LB; ops[1] = LS_LH; ops[2] = LS_LW; ops[3] = LS_LBU; ops[4] = LS_LHU;
        for (int w = 0; w < 256; w++) set_word(4 * w, $urandom);
        i_reset = 1'b0; i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
        i_ls_op = 3'b000; i_addr = '0; i_store_data = '0;
        repeat (2) @(negedge i_clock);
        check_outputs_zero("reset");
        #4 i_reset = 1'b1;

        // Byte store with a three-cycle memory
        fixed_lat = 3;
        issue(1'b0, 1'b1, LS_LB, 32'h102, 32'h0000_00A5);
        // Byte load, memory answers immediately
        fixed_lat = 0;
        set_word(32'h200, 32'hC912_3456);
        issue(1'b1, 1'b0, LS_LB, 32'h203, 32'h0);
        // Unsigned half load followed back-to-back by a word load
        set_word(32'h010, 32'h8EC9_1234);
        issue(1'b1, 1'b0, LS_LHU, 32'h012, 32'h0);
        issue(1'b1, 1'b0, LS_LW, 32'h014, 32'h0);
        // Read and write together is a store; read it back
        issue(1'b1, 1'b1, LS_LW, 32'h030, 32'hDEAD_BEEF);
        issue(1'b1, 1'b0, LS_LW, 32'h030, 32'h0);
        // Misaligned word / half accesses
        issue(1'b1, 1'b0, LS_LW, 32'h006, 32'h0);
        issue(1'b0, 1'b1, LS_LH, 32'h041, 32'h1234_5678);
        issue(1'b1, 1'b0, LS_LH, 32'h040, 32'h0);

        // Random traffic
        fixed_lat = -1;
        for (int t = 0; t < 250; t++) begin
            if ($urandom_range(0, 4) == 0) idle_cycle();
            sel = $urandom_range(0, 3);
            issue(sel == 2 || sel == 3 || sel == 1, sel == 0 || sel == 1,
                  ops[$urandom_range(0, 4)], $urandom_range(0, 1023), $urandom);
        end

        // Reset in the middle of a pending load
        fixed_lat = 20;
        @(negedge i_clock);
        i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0; i_ls_op = LS_LW; i_addr = 32'h80;
        rq.push_back('{1'b0, 32'h80, 4'b1111, 32'h0, cyc});
        @(negedge i_clock);
        i_valid = 1'b0;
        @(negedge i_clock);
        check("pre_reset_req", o_dmem_req, 1);
        #4 i_reset = 1'b0;
        #1 check_outputs_zero("midreset");
        repeat (2) @(negedge i_clock);
        #4 i_reset = 1'b1;
        fixed_lat = -1;
        inject_ack = 1'b1;
        repeat (4) begin
            @(negedge i_clock);
            check("post_reset_req", o_dmem_req, 0);
            check("post_reset_load_valid", o_load_valid, 0);
        end

        // Normal operation resumes
        for (int t = 0; t < 20; t++)
            issue(1'b1, 1'(t % 2), ops[t % 5], $urandom_range(0, 1023), $urandom);

        idle_cycle();
        repeat (4) @(negedge i_clock);
        check("req_queue_empty", rq.size(), 0);
        check("load_queue_empty", lq.size(), 0);
        check("misalign_queue_empty", mq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter PROC_BITS, default `PROC_BITS (32), datapath width.
REQ-002 SHALL have ports, one per line:
  i_clock  in  1  single clock, rising edge
  i_reset  in  1  asynchronous, active-low reset
  i_valid  in  1  MEM-stage instruction valid
  i_mem_read  in  1  load request
  i_mem_write  in  1  store request
  i_ls_op  in  3  size/sign code; bits[1:0]: 00 byte, 01 half, 11 word
  i_addr  in  PROC_BITS  byte address
  i_store_data  in  PROC_BITS  store source register
  o_stall  out  1  freeze upstream pipeline
  o_dmem_req  out  1  data-memory request
  o_dmem_we  out  1  write enable
  o_dmem_addr  out  PROC_BITS  word address, bits[1:0]=00
  o_dmem_wdata  out  PROC_BITS  lane-replicated write data
  o_dmem_be  out  4  byte enables, bit n = byte lane n (little-endian)
  i_dmem_ack  in  1  memory completion, one cycle
  i_dmem_rdata  in  PROC_BITS  read word, valid with ack
  o_load_data  out  PROC_BITS  right-aligned raw word for the load filter
  o_load_op  out  3  i_ls_op of the completed load
  o_load_valid  out  1  one-cycle pulse, load result ready
  o_misalign  out  1  misalignment trap pulse (see Configuration)

Function
REQ-003 SHALL implement FSM IDLE, WAIT.
REQ-004 IDLE: i_valid & (i_mem_read | i_mem_write) SHALL latch addr/op/data/direction and go to WAIT; otherwise stay.
REQ-005 i_mem_read & i_mem_write together SHALL be treated as a store; the read is dropped.
REQ-006 o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be SHALL be registered and held constant throughout WAIT.
REQ-007 WAIT with i_dmem_ack SHALL go to IDLE and deassert o_dmem_req on the next edge; without ack, remain in WAIT indefinitely.
REQ-008 o_stall SHALL be combinational: (IDLE & accepted access) | (WAIT & ~i_dmem_ack); upstream advances in the ack cycle.
REQ-009 i_dmem_ack in IDLE SHALL be ignored.
REQ-010 Store lanes: byte be=1<<a[1:0], wdata=4x data[7:0]; half be=a[1]?1100:0011, wdata=2x data[15:0]; word be=1111, wdata=data.
REQ-011 Reads SHALL drive be=1111, we=0.
REQ-012 On load ack, o_load_data SHALL register rdata>>(8*a[1:0]) for byte, rdata>>(16*a[1]) for half, rdata for word; zero-fill upper bits; o_load_valid pulses the following cycle with o_load_op.
REQ-013 Stores SHALL never assert o_load_valid; o_load_data holds its last value.
REQ-014 A new access SHALL be accepted in the IDLE cycle immediately after an ack (back-to-back, 2 cycles minimum per access with 1-cycle memory).

Reset
REQ-015 i_reset low SHALL immediately force IDLE and all registered outputs to 0 (o_dmem_req, o_load_valid, o_load_data, o_load_op, o_misalign, o_dmem_*), aborting any access in flight; a late ack after release is ignored per REQ-009.

Configuration
REQ-016 Macro MISALIGN_TRAP_EN defined: half with a[0]=1 or word with a[1:0]!=00 SHALL issue no memory request, no stall, no load_valid, and pulse o_misalign for one cycle.
REQ-017 Macro undefined: offending low address bits SHALL be ignored (half uses a[1], word uses neither) and o_misalign tied 0.

Structure
REQ-018 PROC_BITS and the ls_op encodings (LB 000, LH 001, LW 011, LBU 100, LHU 101) SHALL come from shared constants.vh.
REQ-019 Lane steering (REQ-010/012) SHALL be a combinational sub-module mem_lane_align; FSM stays in mem_access_ctrl.

Verification
REQ-020 SB data 0x000000A5 addr 0x102, ack after 3 cycles -> be=0100, wdata=0xA5A5A5A5, addr 0x100, stall 4 cycles, no load_valid.
REQ-021 LB addr 0x203, rdata 0xC9123456 same-cycle ack -> o_load_data 0x000000C9, o_load_op 000, load_valid one cycle after ack.
REQ-022 LHU addr 0x012, rdata 0x8E C9 xxxx -> o_load_data 0x00008EC9; back-to-back LW addr 0x014 accepted the cycle after ack.
REQ-023 Read+write asserted together -> store performed, we=1, no load_valid.
REQ-024 Reset asserted mid-WAIT -> req drops immediately, IDLE, outputs 0; ack afterwards ignored.
REQ-025 LW addr 0x006: with MISALIGN_TRAP_EN -> o_misalign one cycle, no req; without -> req addr 0x004, normal completion.
